// File: rtl/sort_seq_ctrl.sv
// sort_seq_ctrl: burst sort controller.
// Loads N elements through a valid/ready port and sorts them in place with an
// odd-even transposition network, one phase per clock. The compare-swap rule
// is chosen per burst. The result is then streamed out through a second
// valid/ready port. Sorting stops early once two consecutive phases make no swap.
module sort_seq_ctrl #(
    parameter int N  = 8,
    parameter int W  = 4,
    parameter int PW = $clog2(N) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    input  logic [1:0]    mode,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic          out_last,
    output logic          busy,
    output logic [PW-1:0] sort_phases
);

    localparam int AW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SORT  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // Compare-swap rule: returns 1 when the pair (lo, hi) must be exchanged.
    // Equal keys never swap, which keeps every rule stable.
    function automatic logic swap_rule(input logic [1:0] m,
                                       input logic [W-1:0] lo,
                                       input logic [W-1:0] hi);
        logic sw;
        case (m)
            2'd0: sw = (lo > hi);
            2'd1: sw = (lo < hi);
            2'd2: sw = (~lo[0]) & hi[0];
            2'd3: begin
                if (lo[0] != hi[0]) begin
                    sw = ~lo[0];
                end else if (lo[0]) begin
                    sw = (lo > hi);
                end else begin
                    sw = (lo < hi);
                end
            end
            default: sw = 1'b0;
        endcase
        return sw;
    endfunction

    state_t          state_q, state_d;
    logic [W-1:0]    arr_q [N];
    logic [W-1:0]    arr_d [N];
    logic [AW-1:0]   wr_cnt_q, wr_cnt_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [1:0]      mode_q, mode_d;
    logic [PW-1:0]   phase_cnt_q, phase_cnt_d;
    logic            zero_run_q, zero_run_d;
    logic [PW-1:0]   sort_phases_q, sort_phases_d;

    // Network signals for the phase currently being executed.
    logic [N-1:0]    pair_swap_s;
    logic [N-1:0]    swap_dn_s;
    logic            any_swap_s;
    logic            phase_odd_s;
    logic [PW-1:0]   phase_next_s;
    logic [W-1:0]    net_s [N];

    assign phase_odd_s  = phase_cnt_q[0];
    assign phase_next_s = phase_cnt_q + {{(PW-1){1'b0}}, 1'b1};

    // One transposition phase: decide every active pair, then route elements.
    // Pairs in one phase are disjoint, so each element moves at most one slot.
    always_comb begin
        pair_swap_s = {N{1'b0}};
        for (int k = 0; k < N - 1; k++) begin
            pair_swap_s[k] = ((((k % 2) != 0) ? 1'b1 : 1'b0) == phase_odd_s)
                             && swap_rule(mode_q, arr_q[k], arr_q[k+1]);
        end
        swap_dn_s  = {pair_swap_s[N-2:0], 1'b0};
        any_swap_s = |pair_swap_s;
        for (int i = 0; i < N; i++) begin
            net_s[i] = pair_swap_s[i] ? arr_q[(i + 1) % N] :
                       (swap_dn_s[i] ? arr_q[(i + N - 1) % N] : arr_q[i]);
        end
    end

    // Next-state and datapath update for the load/sort/drain sequence.
    always_comb begin
        state_d       = state_q;
        arr_d         = arr_q;
        wr_cnt_d      = wr_cnt_q;
        rd_ptr_d      = rd_ptr_q;
        mode_d        = mode_q;
        phase_cnt_d   = phase_cnt_q;
        zero_run_d    = zero_run_q;
        sort_phases_d = sort_phases_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    arr_d[0] = in_data;
                    mode_d   = mode;
                    wr_cnt_d = {{(AW-1){1'b0}}, 1'b1};
                    state_d  = ST_LOAD;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (in_valid) begin
                    arr_d[wr_cnt_q] = in_data;
                    if (wr_cnt_q == AW'(N - 1)) begin
                        wr_cnt_d    = {AW{1'b0}};
                        phase_cnt_d = {PW{1'b0}};
                        zero_run_d  = 1'b0;
                        state_d     = ST_SORT;
                    end else begin
                        wr_cnt_d    = wr_cnt_q + {{(AW-1){1'b0}}, 1'b1};
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_SORT: begin
                arr_d       = net_s;
                phase_cnt_d = phase_next_s;
                zero_run_d  = ~any_swap_s;
                // Stable after an even and an odd phase with no swaps, or
                // the N-phase bound that guarantees a sorted array.
                if ((~any_swap_s && zero_run_q) || (phase_next_s == PW'(N))) begin
                    sort_phases_d = phase_next_s;
                    rd_ptr_d      = {AW{1'b0}};
                    state_d       = ST_DRAIN;
                end else begin
                    state_d       = ST_SORT;
                end
            end
            ST_DRAIN: begin
                if (out_ready) begin
                    if (rd_ptr_q == AW'(N - 1)) begin
                        rd_ptr_d = {AW{1'b0}};
                        state_d  = ST_IDLE;
                    end else begin
                        rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
                    end
                end else begin
                    rd_ptr_d = rd_ptr_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, array and counter registers; reset aborts any burst in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            for (int i = 0; i < N; i++) begin
                arr_q[i] <= {W{1'b0}};
            end
            wr_cnt_q      <= {AW{1'b0}};
            rd_ptr_q      <= {AW{1'b0}};
            mode_q        <= 2'd0;
            phase_cnt_q   <= {PW{1'b0}};
            zero_run_q    <= 1'b0;
            sort_phases_q <= {PW{1'b0}};
        end else begin
            state_q       <= state_d;
            arr_q         <= arr_d;
            wr_cnt_q      <= wr_cnt_d;
            rd_ptr_q      <= rd_ptr_d;
            mode_q        <= mode_d;
            phase_cnt_q   <= phase_cnt_d;
            zero_run_q    <= zero_run_d;
            sort_phases_q <= sort_phases_d;
        end
    end

    // Outputs come only from registers, so there is no input-to-output path.
    assign in_ready    = (state_q == ST_IDLE) || (state_q == ST_LOAD);
    assign out_valid   = (state_q == ST_DRAIN);
    assign out_data    = (state_q == ST_DRAIN) ? arr_q[rd_ptr_q] : {W{1'b0}};
    assign out_last    = (state_q == ST_DRAIN) && (rd_ptr_q == AW'(N - 1));
    assign busy        = (state_q != ST_IDLE);
    assign sort_phases = sort_phases_q;

endmodule

// File: tb/tb_sort_seq_ctrl.sv
// Scoreboard bench for sort_seq_ctrl: each burst pushes its hand-computed
// sorted sequence into a queue. A monitor checks every presented output
// against the queue head and pops it on each accepted handshake.
module tb_sort_seq_ctrl;

    localparam int N  = 8;
    localparam int W  = 4;
    localparam int PW = $clog2(N) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [1:0]    mode;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          out_last;
    logic          busy;
    logic [PW-1:0] sort_phases;

    typedef struct packed {
        logic [W-1:0] d;
        logic         l;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    bit   stress_en = 1'b0;

    sort_seq_ctrl #(.N(N), .W(W), .PW(PW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .mode       (mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy),
        .sort_phases(sort_phases)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitor: compare the presented element with the queue head every cycle
    // (which also proves it is held while stalled), pop on acceptance.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", int'(out_data), -1);
                end else begin
                    chk("out_data", int'(out_data), int'(exp_q[0].d));
                    chk("out_last", int'(out_last), int'(exp_q[0].l));
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    // Consumer: always ready, or the 1,0,0,1 pattern under stress.
    initial begin
        logic [3:0] pat;
        int k;
        pat = 4'b1001;
        k = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stress_en) begin
                out_ready = pat[k % 4];
                k++;
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    // Load one burst; elements are nibbles of vin, leftmost first.
    task automatic send_burst(input logic [1:0] m, input logic [31:0] vin,
                              input logic [31:0] vexp, input bit stress);
        exp_t e;
        int tmo;
        for (int i = 0; i < N; i++) begin
            e.d = vexp[31-4*i -: 4];
            e.l = (i == N - 1);
            exp_q.push_back(e);
        end
        for (int i = 0; i < N; i++) begin
            if (stress) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
            in_valid = 1'b1;
            in_data  = vin[31-4*i -: 4];
            mode     = (i == 0 || !stress) ? m : ~m;
            tmo = 0;
            while (!in_ready && tmo < 50) begin
                @(posedge clk);
                #1;
                tmo++;
            end
            if (tmo >= 50) chk("in_ready_timeout", tmo, 0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        mode     = ~m;
    endtask

    // Count cycles from SORT entry until out_valid rises.
    task automatic wait_out_valid(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic wait_drain();
        int tmo;
        tmo = 0;
        while ((exp_q.size() != 0 || busy) && tmo < 300) begin
            @(posedge clk);
            #1;
            tmo++;
        end
        chk("drain_timeout", int'(tmo >= 300), 0);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_out_valid"}, int'(out_valid), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_sort_phases"}, int'(sort_phases), 0);
        chk({tag, "_in_ready"}, int'(in_ready), 1);
        chk({tag, "_out_last"}, int'(out_last), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 4'd0;
        mode     = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        chk_idle_outputs("reset");
        chk("reset_out_data", int'(out_data), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Ascending, with latency bound.
        send_burst(2'd0, 32'h93F0772C, 32'h023779CF, 1'b0);
        chk("asc_busy_in_sort", int'(busy), 1);
        chk("asc_in_ready_in_sort", int'(in_ready), 0);
        wait_out_valid(cyc);
        chk("asc_latency_le8", int'(cyc <= 8 && cyc >= 2), 1);
        wait_drain();

        // Descending worst case: full N phases.
        send_burst(2'd1, 32'h01234567, 32'h76543210, 1'b0);
        wait_out_valid(cyc);
        chk("desc_drain_cycles", cyc, 8);
        chk("desc_sort_phases", int'(sort_phases), 8);
        wait_drain();
        chk("desc_sort_phases_held", int'(sort_phases), 8);

        // Already sorted: early termination after two phases.
        send_burst(2'd0, 32'h01234567, 32'h01234567, 1'b0);
        wait_out_valid(cyc);
        chk("early_drain_cycles", cyc, 2);
        chk("early_sort_phases", int'(sort_phases), 2);
        wait_drain();

        // Parity partitions.
        send_burst(2'd2, 32'h49278163, 32'h97134286, 1'b0);
        wait_drain();
        send_burst(2'd3, 32'h49278163, 32'h13798642, 1'b0);
        wait_drain();

        // Handshake stress with mode changing mid-load.
        stress_en = 1'b1;
        send_burst(2'd0, 32'hC44A1F69, 32'h14469ACF, 1'b1);
        wait_drain();
        stress_en = 1'b0;
        @(posedge clk);
        #1;

        // Reset during SORT.
        send_burst(2'd1, 32'h01234567, 32'h76543210, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("sort_still_busy", int'(busy), 1);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        chk_idle_outputs("rst_sort");
        rst = 1'b0;

        // Reset during DRAIN after three outputs.
        send_burst(2'd1, 32'h01234567, 32'h76543210, 1'b0);
        cyc = 0;
        while (exp_q.size() > 5 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("drain_three_outputs", exp_q.size(), 5);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        chk_idle_outputs("rst_drain");
        rst = 1'b0;

        // Fresh burst after reset.
        send_burst(2'd0, 32'h5E11803B, 32'h011358BE, 1'b0);
        wait_drain();
        chk("final_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
